// File: rtl/serial_master_port.sv
// serial_master_port: serialises one parallel read/write request onto the 1-bit master bus
// and deserialises read data. Optional read timeout: define SERIAL_MASTER_PORT_TIMEOUT_EN.
module serial_master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  input  logic                  dmode,
  input  logic                  dvalid,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  drvalid,
  output logic                  derr,
  output logic                  mwdata,
  input  logic                  mrdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  svalid,
  input  logic                  sready
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic [TW-1:0]         to_r, to_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic [MAXW-1:0]       sh_r, sh_s;
  logic [DATA_WIDTH-1:0] rsh_r, rsh_s;
  logic                  mmode_r, mmode_s;
  logic                  dready_r, dready_s;
  logic [DATA_WIDTH-1:0] drdata_r, drdata_s;
  logic                  drvalid_r, drvalid_s;
  logic                  derr_r, derr_s;
  logic                  mwdata_r, mwdata_s;
  logic                  mvalid_r, mvalid_s;

  // Next-state and next-output logic; every output is computed one cycle ahead and registered.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    to_s      = to_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    sh_s      = sh_r;
    rsh_s     = rsh_r;
    mmode_s   = mmode_r;
    dready_s  = dready_r;
    drdata_s  = drdata_r;
    drvalid_s = 1'b0;
    derr_s    = 1'b0;
    mwdata_s  = mwdata_r;
    mvalid_s  = mvalid_r;
    case (state_r)
      S_IDLE: begin
        if (dvalid) begin
          addr_s   = daddr;
          wdata_s  = dwdata;
          mmode_s  = dmode;
          dready_s = 1'b0;
          cnt_s    = '0;
          state_s  = S_REQ;
        end else begin
          dready_s = 1'b1;
        end
      end
      S_REQ: begin
        if (sready) begin
          mvalid_s = 1'b1;
          mwdata_s = addr_r[0];
          sh_s     = MAXW'(addr_r >> 1);
          cnt_s    = '0;
          state_s  = S_ADDR;
        end else begin
          mvalid_s = 1'b0;
        end
      end
      S_ADDR: begin
        if (cnt_r == CW'(ADDR_WIDTH - 1)) begin
          cnt_s = '0;
          if (mmode_r) begin
            mwdata_s = wdata_r[0];
            sh_s     = MAXW'(wdata_r >> 1);
            state_s  = S_WDATA;
          end else begin
            mvalid_s = 1'b0;
            mwdata_s = 1'b0;
            rsh_s    = '0;
            to_s     = '0;
            state_s  = S_RDATA;
          end
        end else begin
          cnt_s    = cnt_r + CW'(1);
          mwdata_s = sh_r[0];
          sh_s     = sh_r >> 1;
        end
      end
      S_WDATA: begin
        if (cnt_r == CW'(DATA_WIDTH - 1)) begin
          cnt_s    = '0;
          mvalid_s = 1'b0;
          mwdata_s = 1'b0;
          dready_s = 1'b1;
          state_s  = S_IDLE;
        end else begin
          cnt_s    = cnt_r + CW'(1);
          mwdata_s = sh_r[0];
          sh_s     = sh_r >> 1;
        end
      end
      S_RDATA: begin
        if (svalid) begin
          // Bits arrive LSB first, so each new bit enters at the top and the word shifts down.
          rsh_s = DATA_WIDTH'({mrdata, rsh_r} >> 1);
          to_s  = '0;
          if (cnt_r == CW'(DATA_WIDTH - 1)) begin
            cnt_s     = '0;
            drdata_s  = rsh_s;
            drvalid_s = 1'b1;
            dready_s  = 1'b1;
            state_s   = S_IDLE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
          if (to_r == TW'(TIMEOUT - 1)) begin
            to_s      = '0;
            cnt_s     = '0;
            drdata_s  = '0;
            drvalid_s = 1'b1;
            derr_s    = 1'b1;
            dready_s  = 1'b1;
            state_s   = S_IDLE;
          end else begin
            to_s = to_r + TW'(1);
          end
`else
          to_s = to_r;
`endif
        end
      end
      default: begin
        state_s  = S_IDLE;
        cnt_s    = '0;
        mvalid_s = 1'b0;
        mwdata_s = 1'b0;
        dready_s = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      to_r      <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      sh_r      <= '0;
      rsh_r     <= '0;
      mmode_r   <= 1'b0;
      dready_r  <= 1'b1;
      drdata_r  <= '0;
      drvalid_r <= 1'b0;
      derr_r    <= 1'b0;
      mwdata_r  <= 1'b0;
      mvalid_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      to_r      <= to_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      sh_r      <= sh_s;
      rsh_r     <= rsh_s;
      mmode_r   <= mmode_s;
      dready_r  <= dready_s;
      drdata_r  <= drdata_s;
      drvalid_r <= drvalid_s;
      derr_r    <= derr_s;
      mwdata_r  <= mwdata_s;
      mvalid_r  <= mvalid_s;
    end
  end

  assign dready  = dready_r;
  assign drdata  = drdata_r;
  assign drvalid = drvalid_r;
  assign derr    = derr_r;
  assign mwdata  = mwdata_r;
  assign mmode   = mmode_r;
  assign mvalid  = mvalid_r;

endmodule

// File: tb/tb_serial_master_port.sv
// Directed bench for serial_master_port: write/read framing, sready stalls, ignored requests,
// mid-transfer reset and read timeout (SERIAL_MASTER_PORT_TIMEOUT_EN) or its absence.
module tb_serial_master_port;

`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
  localparam int TO_P = 16;
`else
  localparam int TO_P = 255;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] daddr = 12'h000;
  logic [7:0]  dwdata = 8'h00;
  logic        dmode = 1'b0;
  logic        dvalid = 1'b0;
  logic        dready;
  logic [7:0]  drdata;
  logic        drvalid;
  logic        derr;
  logic        mwdata;
  logic        mrdata = 1'b0;
  logic        mmode;
  logic        mvalid;
  logic        svalid = 1'b0;
  logic        sready = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses;
  int hit;
  logic [19:0] e;
  logic [7:0]  rd_val;

  always #5 clk = ~clk;

  serial_master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT(TO_P)) dut (
    .clk(clk), .rstn(rstn), .daddr(daddr), .dwdata(dwdata), .dmode(dmode),
    .dvalid(dvalid), .dready(dready), .drdata(drdata), .drvalid(drvalid),
    .derr(derr), .mwdata(mwdata), .mrdata(mrdata), .mmode(mmode),
    .mvalid(mvalid), .svalid(svalid), .sready(sready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects n serial bits, LSB of bits first, one per cycle with mvalid high.
  task automatic stream(input string tag, input logic [19:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_mvalid"}, 32'(mvalid), 32'd1);
      chk({tag, "_bit"}, 32'(mwdata), 32'(bits[i]));
    end
  endtask

  initial begin
    // Reset values (a clock edge has passed with rstn low)
    #12;
    chk("rst_dready", 32'(dready), 32'd1);
    chk("rst_mvalid", 32'(mvalid), 32'd0);
    chk("rst_mwdata", 32'(mwdata), 32'd0);
    chk("rst_mmode", 32'(mmode), 32'd0);
    chk("rst_drvalid", 32'(drvalid), 32'd0);
    chk("rst_derr", 32'(derr), 32'd0);
    chk("rst_drdata", 32'(drdata), 32'd0);
    rstn = 1'b1;
    sready = 1'b1;
    tick();

    // Write 0x5A3 / 0xC6
    daddr = 12'h5A3; dwdata = 8'hC6; dmode = 1'b1; dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    chk("wr_req_dready", 32'(dready), 32'd0);
    chk("wr_req_mmode", 32'(mmode), 32'd1);
    chk("wr_req_mvalid", 32'(mvalid), 32'd0);
    e = 20'b11000110_010110100011;
    stream("wr", e, 20);
    tick();
    chk("wr_end_dready", 32'(dready), 32'd1);
    chk("wr_end_mvalid", 32'(mvalid), 32'd0);
    chk("wr_end_mmode", 32'(mmode), 32'd1);

    // Read 0x010, slave returns 0x3C with 2-cycle svalid gaps
    daddr = 12'h010; dmode = 1'b0; dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    chk("rd_mmode", 32'(mmode), 32'd0);
    e = 20'h00010;
    stream("rd_addr", e, 12);
    tick();
    chk("rd_wait_mvalid", 32'(mvalid), 32'd0);
    rd_val = 8'h3C;
    pulses = 0;
    for (int b = 0; b < 8; b++) begin
      svalid = 1'b0;
      tick(); pulses += int'(drvalid);
      tick(); pulses += int'(drvalid);
      svalid = 1'b1; mrdata = rd_val[b];
      tick();
      if (b < 7) pulses += int'(drvalid);
    end
    svalid = 1'b0; mrdata = 1'b0;
    chk("rd_early_pulses", 32'(pulses), 32'd0);
    chk("rd_drvalid", 32'(drvalid), 32'd1);
    chk("rd_drdata", 32'(drdata), 32'h3C);
    chk("rd_derr", 32'(derr), 32'd0);
    chk("rd_dready", 32'(dready), 32'd1);
    tick();
    chk("rd_pulse_single", 32'(drvalid), 32'd0);

    // Read that never receives data: timeout abort, or indefinite wait
    daddr = 12'h123; dmode = 1'b0; dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    e = 20'h00123;
    stream("to_addr", e, 12);
`ifdef SERIAL_MASTER_PORT_TIMEOUT_EN
    hit = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (drvalid === 1'b1) begin
        hit = c;
        break;
      end
    end
    chk("to_cycle", 32'(hit), 32'd16);
    chk("to_derr", 32'(derr), 32'd1);
    chk("to_drdata", 32'(drdata), 32'h00);
    chk("to_dready", 32'(dready), 32'd1);
    tick();
`else
    pulses = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      pulses += int'(drvalid) + int'(derr);
    end
    chk("noto_pulses", 32'(pulses), 32'd0);
    chk("noto_dready", 32'(dready), 32'd0);
    chk("noto_drdata", 32'(drdata), 32'h3C);
    #2 rstn = 1'b0;
    tick();
    #3 rstn = 1'b1;
    tick();
`endif

    // sready low for 5 cycles after accept, then dropped mid-ADDR
    sready = 1'b0;
    daddr = 12'h0A5; dwdata = 8'h3C; dmode = 1'b1; dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("sr_wait_mvalid", 32'(mvalid), 32'd0);
      tick();
    end
    sready = 1'b1;
    chk("sr_rise_mvalid", 32'(mvalid), 32'd0);
    e = {8'h3C, 12'h0A5};
    stream("sr1", e, 4);
    sready = 1'b0;
    e = e >> 4;
    stream("sr2", e, 16);
    sready = 1'b1;
    tick();
    chk("sr_end_dready", 32'(dready), 32'd1);
    chk("sr_end_mvalid", 32'(mvalid), 32'd0);

    // dvalid pulsed with another request during a write is ignored
    daddr = 12'h3C1; dwdata = 8'h5A; dmode = 1'b1; dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    e = {8'h5A, 12'h3C1};
    stream("ign1", e, 5);
    daddr = 12'h7FF; dwdata = 8'h00; dmode = 1'b0; dvalid = 1'b1;
    e = e >> 5;
    stream("ign2", e, 1);
    dvalid = 1'b0;
    e = e >> 1;
    stream("ign3", e, 14);
    tick();
    chk("ign_end_dready", 32'(dready), 32'd1);
    chk("ign_mmode", 32'(mmode), 32'd1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(mvalid) + int'(!dready);
    end
    chk("ign_no_second", 32'(pulses), 32'd0);

    // Reset at address bit 4, then a clean write 0x001 / 0xFF
    daddr = 12'h7E5; dwdata = 8'h81; dmode = 1'b1; dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    e = {8'h81, 12'h7E5};
    stream("rst_pre", e, 5);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_mvalid", 32'(mvalid), 32'd0);
    chk("rst_mid_dready", 32'(dready), 32'd1);
    tick();
    tick();
    #3 rstn = 1'b1;
    daddr = 12'h001; dwdata = 8'hFF; dmode = 1'b1; dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    chk("post_mmode", 32'(mmode), 32'd1);
    e = {8'hFF, 12'h001};
    stream("post", e, 20);
    tick();
    chk("post_dready", 32'(dready), 32'd1);
    chk("post_mvalid", 32'(mvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
